// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU operation classes and control bundles.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LOGIC = 2'b11
  } alu_op_e;

  // Controls that travel down to EX; reg_dest is consumed in ID to pick the destination.
  typedef struct packed {
    logic    salto;
    logic    branch;
    logic    mem_leer;
    logic    mem_a_reg;
    logic    mem_escribir;
    logic    alu_fuente;
    logic    reg_escribir;
    alu_op_e alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic     reg_dest;
    ex_ctrl_t ex;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dest = 1'b1; c.ex.reg_escribir = 1'b1; c.ex.alu_op = ALU_FUNCT;
      end
      OP_LW: begin
        c.ex.reg_escribir = 1'b1; c.ex.alu_fuente = 1'b1;
        c.ex.mem_leer = 1'b1; c.ex.mem_a_reg = 1'b1;
      end
      OP_SW: begin
        c.ex.alu_fuente = 1'b1; c.ex.mem_escribir = 1'b1;
      end
      OP_BEQ: begin
        c.ex.branch = 1'b1; c.ex.alu_op = ALU_SUB;
      end
      OP_J: c.ex.salto = 1'b1;
      OP_ADDI: begin
        c.ex.reg_escribir = 1'b1; c.ex.alu_fuente = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        c.ex.reg_escribir = 1'b1; c.ex.alu_fuente = 1'b1; c.ex.alu_op = ALU_LOGIC;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/banco_registros_bypass.sv
// 32-entry register file: async-clear, r0 hardwired to zero, optional same-cycle write-back forwarding.
module banco_registros_bypass #(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [31:0][DATA_W-1:0] regs_q, regs_d;
  logic                    wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] leer(input logic [4:0] a);
    if (a == 5'd0)                          return '0;
    else if (BYPASS_WB && wr_en && a == wa) return wd;
    else                                    return regs_q[a];
  endfunction

  assign rd1 = leer(ra1);
  assign rd2 = leer(ra2);

endmodule

// File: rtl/etapa_id_pipe.sv
// MIPS decode stage: control decode, operand read, immediate/jump formation,
// load-use stall, flush-to-bubble and the ID/EX pipeline register.
module etapa_id_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_WB = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruccion,
  input  logic [31:0]       pc_plus4_in,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              wb_escribir,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_dato,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_salto,
  output logic              ex_branch,
  output logic              ex_mem_leer,
  output logic              ex_mem_a_reg,
  output logic              ex_mem_escribir,
  output logic              ex_alu_fuente,
  output logic              ex_reg_escribir,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_dr1,
  output logic [DATA_W-1:0] ex_dr2,
  output logic [DATA_W-1:0] ex_ext,
  output logic [5:0]        ex_funct,
  output logic [31:0]       ex_pc_plus4,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_reg_dest,
  output logic [31:0]       ex_jump_addr
);

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  ctrl_t      ctrl;
  logic       issue, usa_rt, stall_c;

  logic [DATA_W-1:0] dr1, dr2, ext;

  assign opcode = instruccion[31:26];
  assign rs     = instruccion[25:21];
  assign rt     = instruccion[20:16];
  assign rd     = instruccion[15:11];
  assign ctrl   = decode_ctrl(opcode);

  banco_registros_bypass #(.DATA_W(DATA_W), .BYPASS_WB(BYPASS_WB)) u_banco (
    .clk (clk),
    .rst_n (rst_n),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (dr1),
    .rd2 (dr2),
    .we  (wb_escribir),
    .wa  (wb_reg),
    .wd  (wb_dato)
  );

  always_comb begin
    if (opcode == OP_ANDI || opcode == OP_ORI)
      ext = {{(DATA_W-16){1'b0}}, instruccion[15:0]};
    else
      ext = {{(DATA_W-16){instruccion[15]}}, instruccion[15:0]};
  end

  // ID/EX state
  logic              ex_valid_q, ex_valid_d;
  ex_ctrl_t          ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_dr1_q, ex_dr1_d, ex_dr2_q, ex_dr2_d, ex_ext_q, ex_ext_d;
  logic [5:0]        ex_funct_q, ex_funct_d;
  logic [31:0]       ex_pc_plus4_q, ex_pc_plus4_d, ex_jump_addr_q, ex_jump_addr_d;
  logic [4:0]        ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d, ex_reg_dest_q, ex_reg_dest_d;

  // rt is only a source for instructions that read two registers.
  assign usa_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);

  always_comb begin
    stall_c = 1'b0;
    if (HAZARD_EN)
      stall_c = valid_in && ex_valid_q && ex_ctrl_q.mem_leer && (ex_reg_dest_q != 5'd0) &&
                ((ex_reg_dest_q == rs) || (usa_rt && ex_reg_dest_q == rt));
  end

  assign stall = stall_c && !flush;
  assign issue = valid_in && !flush && !stall_c;

  // Bubbles clear valid and controls; data fields simply hold.
  always_comb begin
    ex_valid_d     = issue;
    ex_ctrl_d      = issue ? ctrl.ex : '0;
    ex_dr1_d       = ex_dr1_q;
    ex_dr2_d       = ex_dr2_q;
    ex_ext_d       = ex_ext_q;
    ex_funct_d     = ex_funct_q;
    ex_pc_plus4_d  = ex_pc_plus4_q;
    ex_rt_d        = ex_rt_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_dest_d  = ex_reg_dest_q;
    ex_jump_addr_d = ex_jump_addr_q;
    if (issue) begin
      ex_dr1_d       = dr1;
      ex_dr2_d       = dr2;
      ex_ext_d       = ext;
      ex_funct_d     = instruccion[5:0];
      ex_pc_plus4_d  = pc_plus4_in;
      ex_rt_d        = rt;
      ex_rd_d        = rd;
      ex_reg_dest_d  = ctrl.reg_dest ? rd : rt;
      ex_jump_addr_d = {pc_plus4_in[31:28], instruccion[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_dr1_q       <= '0;
      ex_dr2_q       <= '0;
      ex_ext_q       <= '0;
      ex_funct_q     <= '0;
      ex_pc_plus4_q  <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_reg_dest_q  <= '0;
      ex_jump_addr_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_dr1_q       <= ex_dr1_d;
      ex_dr2_q       <= ex_dr2_d;
      ex_ext_q       <= ex_ext_d;
      ex_funct_q     <= ex_funct_d;
      ex_pc_plus4_q  <= ex_pc_plus4_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_dest_q  <= ex_reg_dest_d;
      ex_jump_addr_q <= ex_jump_addr_d;
    end
  end

  assign ex_valid        = ex_valid_q;
  assign ex_salto        = ex_ctrl_q.salto;
  assign ex_branch       = ex_ctrl_q.branch;
  assign ex_mem_leer     = ex_ctrl_q.mem_leer;
  assign ex_mem_a_reg    = ex_ctrl_q.mem_a_reg;
  assign ex_mem_escribir = ex_ctrl_q.mem_escribir;
  assign ex_alu_fuente   = ex_ctrl_q.alu_fuente;
  assign ex_reg_escribir = ex_ctrl_q.reg_escribir;
  assign ex_alu_op       = ex_ctrl_q.alu_op;
  assign ex_dr1          = ex_dr1_q;
  assign ex_dr2          = ex_dr2_q;
  assign ex_ext          = ex_ext_q;
  assign ex_funct        = ex_funct_q;
  assign ex_pc_plus4     = ex_pc_plus4_q;
  assign ex_rt           = ex_rt_q;
  assign ex_rd           = ex_rd_q;
  assign ex_reg_dest     = ex_reg_dest_q;
  assign ex_jump_addr    = ex_jump_addr_q;

endmodule

// File: tb/tb_etapa_id_pipe.sv
// Directed bench for etapa_id_pipe; a second instance without write-back bypass shares the stimulus.
module tb_etapa_id_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruccion, pc_plus4_in, wb_dato;
  logic        valid_in, flush, wb_escribir;
  logic [4:0]  wb_reg;

  logic        stall, ex_valid, ex_salto, ex_branch, ex_mem_leer, ex_mem_a_reg;
  logic        ex_mem_escribir, ex_alu_fuente, ex_reg_escribir;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_dr1, ex_dr2, ex_ext, ex_pc_plus4, ex_jump_addr;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_rt, ex_rd, ex_reg_dest;

  logic        nb_stall, nb_valid, nb_salto, nb_branch, nb_mem_leer, nb_mem_a_reg;
  logic        nb_mem_escribir, nb_alu_fuente, nb_reg_escribir;
  logic [1:0]  nb_alu_op;
  logic [31:0] nb_dr1, nb_dr2, nb_ext, nb_pc_plus4, nb_jump_addr;
  logic [5:0]  nb_funct;
  logic [4:0]  nb_rt, nb_rd, nb_reg_dest;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  etapa_id_pipe #(.DATA_W(32), .BYPASS_WB(1'b1), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instruccion(instruccion), .pc_plus4_in(pc_plus4_in),
    .valid_in(valid_in), .flush(flush), .wb_escribir(wb_escribir), .wb_reg(wb_reg),
    .wb_dato(wb_dato), .stall(stall), .ex_valid(ex_valid), .ex_salto(ex_salto),
    .ex_branch(ex_branch), .ex_mem_leer(ex_mem_leer), .ex_mem_a_reg(ex_mem_a_reg),
    .ex_mem_escribir(ex_mem_escribir), .ex_alu_fuente(ex_alu_fuente),
    .ex_reg_escribir(ex_reg_escribir), .ex_alu_op(ex_alu_op), .ex_dr1(ex_dr1),
    .ex_dr2(ex_dr2), .ex_ext(ex_ext), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_dest(ex_reg_dest), .ex_jump_addr(ex_jump_addr)
  );

  etapa_id_pipe #(.DATA_W(32), .BYPASS_WB(1'b0), .HAZARD_EN(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .instruccion(instruccion), .pc_plus4_in(pc_plus4_in),
    .valid_in(valid_in), .flush(flush), .wb_escribir(wb_escribir), .wb_reg(wb_reg),
    .wb_dato(wb_dato), .stall(nb_stall), .ex_valid(nb_valid), .ex_salto(nb_salto),
    .ex_branch(nb_branch), .ex_mem_leer(nb_mem_leer), .ex_mem_a_reg(nb_mem_a_reg),
    .ex_mem_escribir(nb_mem_escribir), .ex_alu_fuente(nb_alu_fuente),
    .ex_reg_escribir(nb_reg_escribir), .ex_alu_op(nb_alu_op), .ex_dr1(nb_dr1),
    .ex_dr2(nb_dr2), .ex_ext(nb_ext), .ex_funct(nb_funct), .ex_pc_plus4(nb_pc_plus4),
    .ex_rt(nb_rt), .ex_rd(nb_rd), .ex_reg_dest(nb_reg_dest), .ex_jump_addr(nb_jump_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic [31:0] ins);
    instruccion = ins;
    valid_in    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; instruccion = '0; pc_plus4_in = 32'h0040_0004; valid_in = 1'b0;
    flush = 1'b0; wb_escribir = 1'b0; wb_reg = '0; wb_dato = '0;
    tick; tick;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ex_dr1", ex_dr1, 0);
    chk("rst_ex_jump_addr", ex_jump_addr, 0);
    chk("rst_ex_ctrl", {ex_reg_escribir, ex_mem_leer, ex_alu_op}, 0);
    rst_n = 1'b1;

    // write r5 = 0x1234, then add r3,r5,r0
    wb_escribir = 1'b1; wb_reg = 5'd5; wb_dato = 32'h1234;
    tick;
    wb_escribir = 1'b0;
    decode(32'h00A0_1820);
    tick;
    chk("add_valid", ex_valid, 1);
    chk("add_dr1", ex_dr1, 32'h1234);
    chk("add_reg_dest", ex_reg_dest, 3);
    chk("add_alu_op", ex_alu_op, 2'b10);
    chk("add_reg_escribir", ex_reg_escribir, 1);
    chk("add_funct", ex_funct, 6'h20);
    chk("add_pc_plus4", ex_pc_plus4, 32'h0040_0004);

    // sw r7,4(r0) with same-cycle write-back of r7
    decode(32'hAC07_0004);
    wb_escribir = 1'b1; wb_reg = 5'd7; wb_dato = 32'hDEAD;
    tick;
    wb_escribir = 1'b0;
    chk("sw_dr2_bypass", ex_dr2, 32'hDEAD);
    chk("sw_dr2_nobypass", nb_dr2, 32'h0);
    chk("sw_mem_escribir", ex_mem_escribir, 1);
    chk("sw_reg_escribir", ex_reg_escribir, 0);
    chk("sw_ext", ex_ext, 32'h4);

    // lw r2,0(r1) then add r4,r2,r3: one stall, one bubble
    decode(32'h8C22_0000);
    tick;
    chk("lw_mem_leer", ex_mem_leer, 1);
    chk("lw_reg_dest", ex_reg_dest, 2);
    decode(32'h0043_2020);
    #1;
    chk("lu_stall_rs", stall, 1);
    tick;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", {ex_reg_escribir, ex_mem_leer}, 0);
    chk("lu_stall_released", stall, 0);
    tick;
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_dest", ex_reg_dest, 4);

    // lw then addi r4,r0,1: no dependence
    decode(32'h8C22_0000);
    tick;
    decode(32'h2004_0001);
    #1;
    chk("nohaz_stall", stall, 0);
    tick;
    chk("nohaz_valid", ex_valid, 1);
    chk("nohaz_ext", ex_ext, 32'h1);
    chk("nohaz_alu_fuente", ex_alu_fuente, 1);

    // lw then add r4,r3,r2: dependence through rt
    decode(32'h8C22_0000);
    tick;
    decode(32'h0062_2020);
    #1;
    chk("lu_stall_rt", stall, 1);
    tick;
    chk("lu_rt_bubble", ex_valid, 0);

    // immediates
    decode(32'h3401_8000);
    tick;
    chk("ori_ext", ex_ext, 32'h0000_8000);
    chk("ori_alu_op", ex_alu_op, 2'b11);
    decode(32'h2001_8000);
    tick;
    chk("addi_ext", ex_ext, 32'hFFFF_8000);
    chk("addi_alu_op", ex_alu_op, 2'b00);

    // jump
    pc_plus4_in = 32'h4000_0008;
    decode(32'h0800_0100);
    tick;
    chk("j_salto", ex_salto, 1);
    chk("j_addr", ex_jump_addr, 32'h4000_0400);
    chk("j_reg_escribir", ex_reg_escribir, 0);

    // valid_in low loads a bubble
    valid_in = 1'b0;
    tick;
    chk("invalid_bubble", ex_valid, 0);
    chk("invalid_salto", ex_salto, 0);

    // flush beats a load-use stall
    decode(32'h8C22_0000);
    tick;
    decode(32'h0043_2020);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    tick;
    flush = 1'b0;
    chk("flush_bubble", ex_valid, 0);

    // write to r0 is ignored, including the bypass path
    decode(32'h0000_1820);
    wb_escribir = 1'b1; wb_reg = 5'd0; wb_dato = 32'hFFFF;
    tick;
    wb_escribir = 1'b0;
    chk("r0_bypass", ex_dr1, 0);
    tick;
    chk("r0_read", ex_dr1, 0);

    // reset in the middle of a stall
    decode(32'h8C22_0000);
    tick;
    decode(32'h0043_2020);
    #1;
    chk("mid_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_mem_leer", ex_mem_leer, 0);
    chk("mid_rst_pc", ex_pc_plus4, 0);
    chk("mid_rst_dest", ex_reg_dest, 0);
    tick;
    rst_n = 1'b1;
    // register file was cleared too: r5 reads 0
    decode(32'h00A0_1820);
    tick;
    chk("rf_cleared", ex_dr1, 0);
    chk("post_rst_valid", ex_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/etapa_id_pipe.md
Name: etapa_id_pipe

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline. It merges the control unit, register file, immediate extension and jump-target formation with a registered ID/EX pipeline register. It adds behaviour the current decode block does not have: load-use hazard detection with stall, flush-to-bubble, write-back bypass, and zero-extension for logical immediates. It sits between the IF/ID register and the EX stage.

Parameters:
DATA_W, 32, register-file and datapath width; must be >= 32.
BYPASS_WB, 1, when 1, a same-cycle write-back to the register being read is forwarded to dr1/dr2.
HAZARD_EN, 1, when 1, the load-use stall logic is active; when 0, stall is tied to 0.

Ports:
clk  in  1  clock; all registers update on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
instruccion  in  32  instruction from IF/ID.
pc_plus4_in  in  32  PC+4 from IF/ID.
valid_in  in  1  IF/ID holds a real instruction.
flush  in  1  branch/jump resolved taken; the instruction currently in ID is squashed.
wb_escribir  in  1  write-back enable.
wb_reg  in  5  write-back destination register.
wb_dato  in  DATA_W  write-back data.
stall  out  1  hold PC and IF/ID this cycle (combinational).
ex_valid  out  1  ID/EX holds a real instruction.
ex_salto, ex_branch, ex_mem_leer, ex_mem_a_reg, ex_mem_escribir, ex_alu_fuente, ex_reg_escribir  out  1 each  registered control signals.
ex_alu_op  out  2  registered ALU operation class.
ex_dr1, ex_dr2  out  DATA_W  registered rs and rt operands.
ex_ext  out  DATA_W  registered extended immediate.
ex_funct  out  6  registered instruccion[5:0].
ex_pc_plus4  out  32  registered PC+4.
ex_rt, ex_rd  out  5 each  registered instruccion[20:16] and instruccion[15:11].
ex_reg_dest  out  5  registered destination: rd for R-type, else rt.
ex_jump_addr  out  32  registered {pc_plus4[31:28], instr[25:0], 2'b00}.

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs are 0. All register-file entries are 0. stall is 0.
- Latency: 1 cycle. Inputs sampled at edge N appear on ex_* after edge N.
- Control decode (opcode -> reg_dest, reg_escribir, alu_fuente, mem_leer, mem_escribir, mem_a_reg, branch, salto, alu_op):
  - 0x00 R-type -> rd, 1, 0, 0, 0, 0, 0, 0, 10.
  - 0x23 lw -> rt, 1, 1, 1, 0, 1, 0, 0, 00.
  - 0x2B sw -> rt, 0, 1, 0, 1, 0, 0, 0, 00.
  - 0x04 beq -> rt, 0, 0, 0, 0, 0, 1, 0, 01.
  - 0x02 j -> salto=1, all other controls 0.
  - 0x08 addi -> rt, 1, 1, 0, 0, 0, 0, 0, 00.
  - 0x0C andi and 0x0D ori -> same controls as addi, alu_op 11.
  - Any other opcode -> all controls 0 (NOP).
- Immediate extension: zero-extend for 0x0C and 0x0D; sign-extend instr[15:0] to DATA_W for all other opcodes.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Write occurs at the clock edge when wb_escribir=1 and wb_reg!=0.
  - With BYPASS_WB=1, a read address equal to a nonzero wb_reg with wb_escribir=1 returns wb_dato in the same cycle.
  - Write-back is never blocked by stall or flush.
- Load-use hazard:
  - stall = valid_in & ex_valid & ex_mem_leer & (ex_reg_dest!=0) & (ex_reg_dest==rs, or ex_reg_dest==rt when opcode is R-type, beq or sw).
  - When stall=1, ID/EX loads a bubble (ex_valid=0, all controls 0; data fields don't-care and are held). Upstream keeps instruccion stable, and the instruction is re-decoded the next cycle.
- Flush: flush=1 loads a bubble into ID/EX and forces stall=0. Flush has priority over stall.
- valid_in=0: ID/EX loads a bubble.
- Reset asserted mid-stall clears the pipeline register and stall immediately.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI);
  - ALU_OP encodings;
  - a packed control struct.
- Natural sub-module: banco_registros_bypass (register file with reset, r0 hardwiring and write-back bypass). Decode, hazard logic and the ID/EX register stay in the top level.

Test Plan:
- Reset, then write r5=0x1234 via WB, then decode add r3,r5,r0 (0x00A01820) -> next cycle ex_dr1=0x1234, ex_reg_dest=3, ex_alu_op=10, ex_reg_escribir=1.
- Same-cycle WB r7=0xDEAD while decoding sw r7,4(r0) -> ex_dr2=0xDEAD with BYPASS_WB=1, and 0 with BYPASS_WB=0.
- lw r2,0(r1) followed by add r4,r2,r3 -> stall=1 for exactly one cycle, one bubble (ex_valid=0), then add issues with ex_valid=1. The same sequence with addi r4,r0,1 -> no stall.
- ori r1,r0,0x8000 -> ex_ext=0x00008000. addi r1,r0,0x8000 -> ex_ext=0xFFFF8000.
- j 0x0000100 with pc_plus4=0x40000008 -> ex_salto=1, ex_jump_addr=0x40000400.
- flush asserted together with a load-use stall condition -> stall=0, ex_valid=0. Write to r0 -> r0 still reads 0. rst_n pulsed low mid-stall -> all ex_* outputs are 0 immediately.
